// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared types and constants for the SR flip-flop command front end.
package sr_cmd_pkg;

    typedef enum logic {IDLE, LOCK} state_t;

    localparam int DB_CYCLES_DEF = 4;
    localparam int LOCKOUT_DEF   = 8;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel -- two-flop synchroniser, debounce, rise detect.
//   clk, rst_n : clock, async active-low reset
//   din        : raw asynchronous button input
//   lvl        : debounced level
//   rise       : combinational rising-edge flag of lvl
module debounce_ch
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1, sync2, lvl_q;
    logic [CNT_W-1:0] cnt;

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            lvl_q <= lvl;
            if (sync2 == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                lvl <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced set/clear buttons arbitrated into single-cycle s/r pulses.
//   clk, rst_n       : clock, async active-low reset
//   set_in, clr_in   : raw asynchronous buttons
//   s, r             : registered one-cycle command pulses
//   set_lvl, clr_lvl : debounced levels
//   conflict         : both edges in one IDLE cycle (set wins)
//   drop             : an edge was discarded during lockout
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int LOCKOUT   = LOCKOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic set_lvl,
    output logic clr_lvl,
    output logic conflict,
    output logic drop
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT - 1);

    logic             set_rise, clr_rise, any_rise;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             s_nxt, r_nxt, conflict_nxt, drop_nxt;

    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_set (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (set_in),
        .lvl  (set_lvl),
        .rise (set_rise)
    );

    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (clr_in),
        .lvl  (clr_lvl),
        .rise (clr_rise)
    );

    assign any_rise = set_rise | clr_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            s        <= s_nxt;
            r        <= r_nxt;
            conflict <= conflict_nxt;
            drop     <= drop_nxt;
        end
    end

    // Set has priority over clear, mirroring the flip-flop; edges in LOCK are lost.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = '0;
        s_nxt        = 1'b0;
        r_nxt        = 1'b0;
        conflict_nxt = 1'b0;
        drop_nxt     = 1'b0;
        if (state == IDLE) begin
            state_nxt    = any_rise ? LOCK : IDLE;
            s_nxt        = set_rise;
            r_nxt        = clr_rise & ~set_rise;
            conflict_nxt = set_rise & clr_rise;
        end else begin
            drop_nxt     = any_rise;
            state_nxt    = (lock_cnt == LOCK_LAST) ? IDLE : LOCK;
            lock_cnt_nxt = (lock_cnt == LOCK_LAST) ? '0 : lock_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed self-checking bench for sr_cmd_gen at default parameters.
module tb_sr_cmd_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_in = 1'b0;
    logic clr_in = 1'b0;
    logic s, r, set_lvl, clr_lvl, conflict, drop;
    logic [5:0] obs;
    logic [5:0] exp_v;
    int errors = 0;
    int checks = 0;

    sr_cmd_gen #(.DB_CYCLES(4), .LOCKOUT(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_in  (set_in),
        .clr_in  (clr_in),
        .s       (s),
        .r       (r),
        .set_lvl (set_lvl),
        .clr_lvl (clr_lvl),
        .conflict(conflict),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    // Bit order: {s, r, conflict, drop, set_lvl, clr_lvl}
    assign obs = {s, r, conflict, drop, set_lvl, clr_lvl};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold e=%0d got=%b want=%b", e, obs, 6'b0);
            end
        end
        set_in = 1'b0;
        rst_n  = 1'b1;
        for (int e = 0; e < 10; e++) tick();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle got=%b want=%b", obs, 6'b0);
        end
    endtask

    task automatic test_set_rise();
        set_in = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            exp_v = {e == 6, 1'b0, 1'b0, 1'b0, e >= 5, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL set_rise e=%0d got=%b want=%b", e, obs, exp_v);
            end
        end
        set_in = 1'b0;
        for (int e = 0; e < 12; e++) tick();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL set_fall got=%b want=%b", obs, 6'b0);
        end
    endtask

    task automatic test_glitch();
        clr_in = 1'b1;
        for (int e = 0; e < 13; e++) begin
            if (e == 3) clr_in = 1'b0;
            tick();
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL clr_glitch e=%0d got=%b want=%b", e, obs, 6'b0);
            end
        end
        clr_in = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            exp_v = {1'b0, e == 6, 1'b0, 1'b0, 1'b0, e >= 5};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clr_clean e=%0d got=%b want=%b", e, obs, exp_v);
            end
        end
        clr_in = 1'b0;
        for (int e = 0; e < 12; e++) tick();
    endtask

    task automatic test_conflict();
        set_in = 1'b1;
        clr_in = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            exp_v = {e == 6, 1'b0, e == 6, 1'b0, e >= 5, e >= 5};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL conflict e=%0d got=%b want=%b", e, obs, exp_v);
            end
        end
        set_in = 1'b0;
        clr_in = 1'b0;
        for (int e = 0; e < 14; e++) tick();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL conflict_end got=%b want=%b", obs, 6'b0);
        end
    endtask

    task automatic test_drop();
        set_in = 1'b1;
        for (int e = 0; e < 16; e++) begin
            if (e == 4) clr_in = 1'b1;
            tick();
            exp_v = {e == 6, 1'b0, 1'b0, e == 10, e >= 5, e >= 9};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL drop e=%0d got=%b want=%b", e, obs, exp_v);
            end
        end
        clr_in = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        checks++;
        if (obs !== 6'b000010) begin
            errors++;
            $display("FAIL drop_release got=%b want=%b", obs, 6'b000010);
        end
        clr_in = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            exp_v = {1'b0, e == 6, 1'b0, 1'b0, 1'b1, e >= 5};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL drop_retry e=%0d got=%b want=%b", e, obs, exp_v);
            end
        end
        set_in = 1'b0;
        clr_in = 1'b0;
        for (int e = 0; e < 14; e++) tick();
    endtask

    // Clear rise one cycle before / in the first cycle after LOCK ends.
    task automatic test_lock_boundary();
        for (int run = 0; run < 2; run++) begin
            set_in = 1'b1;
            for (int e = 0; e < 18; e++) begin
                if (e == 9 - run) clr_in = 1'b1;
                tick();
                exp_v = {e == 6,
                         run == 0 && e == 15,
                         1'b0,
                         run == 1 && e == 14,
                         e >= 5,
                         e >= 14 - run};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL lock_edge run=%0d e=%0d got=%b want=%b", run, e, obs, exp_v);
                end
            end
            set_in = 1'b0;
            clr_in = 1'b0;
            for (int e = 0; e < 16; e++) tick();
        end
    endtask

    task automatic test_reset_mid();
        set_in = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL rst_debounce got=%b want=%b", obs, 6'b0);
        end
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            tick();
            exp_v = {e == 6, 1'b0, 1'b0, 1'b0, e >= 5, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_release1 e=%0d got=%b want=%b", e, obs, exp_v);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL rst_lock got=%b want=%b", obs, 6'b0);
        end
        tick();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL rst_lock_hold got=%b want=%b", obs, 6'b0);
        end
        rst_n = 1'b1;
        for (int e = 0; e < 14; e++) begin
            tick();
            exp_v = {e == 6, 1'b0, 1'b0, 1'b0, e >= 5, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_release2 e=%0d got=%b want=%b", e, obs, exp_v);
            end
        end
        set_in = 1'b0;
        for (int e = 0; e < 10; e++) tick();
    endtask

    initial begin
        test_reset();
        test_set_rise();
        test_glitch();
        test_conflict();
        test_drop();
        test_lock_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Front-end stage for the workshop SR flip-flop. Takes two raw, asynchronous, bouncing push-button inputs (set and clear), synchronises and debounces each one, and detects rising edges. It then arbitrates between them and drives single-cycle `s`/`r` command pulses into the downstream SR flip-flop. A post-command lockout window rejects chatter, and conflicts and dropped requests are reported.

## Interface
Parameters:
- `DB_CYCLES`, default 4: consecutive stable synchronised samples required before a debounced level changes. Legal range 2..255.
- `LOCKOUT`, default 8: number of cycles after any issued command during which new edges are dropped. Legal range 1..255.

Ports:
- `clk`  in  1: single clock. All state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `set_in`  in  1: raw set button, asynchronous to `clk`.
- `clr_in`  in  1: raw clear button, asynchronous to `clk`.
- `s`  out  1: set command pulse to the flip-flop. Registered, one cycle wide.
- `r`  out  1: reset command pulse to the flip-flop. Registered, one cycle wide.
- `set_lvl`  out  1: debounced set level.
- `clr_lvl`  out  1: debounced clear level.
- `conflict`  out  1: one-cycle pulse when set and clear rise in the same IDLE cycle.
- `drop`  out  1: one-cycle pulse when any rising edge is discarded during LOCK.

## Operation
- Reset (asynchronous assert, synchronous-to-edge release) clears the following to 0:
  - synchronisers and debounce counters;
  - `set_lvl`, `clr_lvl` and their delayed copies;
  - `s`, `r`, `conflict`, `drop`;
  - lock counter; FSM returns to IDLE.
- Reset mid-debounce or mid-lockout discards all progress.
- If a button is held high through reset release, it produces one `s`/`r` pulse once debounced, because the level resets to 0.
- Per channel:
  - Two-flop synchroniser: `sync1`, then `sync2`.
  - Debounce on each edge:
    - if `sync2 == lvl`: `cnt <= 0`;
    - else if `cnt == DB_CYCLES-1`: `lvl <= sync2`, `cnt <= 0`;
    - else `cnt <= cnt+1`.
  - A glitch shorter than `DB_CYCLES` synchronised samples never changes `lvl`.
  - Rise flag (combinational) = `lvl & ~lvl_q`, where `lvl_q` is `lvl` delayed one cycle. Falling edges generate nothing.
- Arbiter FSM, states IDLE and LOCK:
  - IDLE, set rise only: `s <= 1`, go to LOCK.
  - IDLE, clear rise only: `r <= 1`, go to LOCK.
  - IDLE, both rise in the same cycle: `s <= 1`, `conflict <= 1`, `r` stays 0, go to LOCK. Set wins, matching the flip-flop's priority.
  - Entering LOCK: `lock_cnt <= 0`.
  - LOCK: `lock_cnt` increments each cycle. At `lock_cnt == LOCKOUT-1`, return to IDLE. LOCK therefore lasts exactly `LOCKOUT` cycles.
  - Any rise flag seen while in LOCK: `drop <= 1`. The edge is lost, not queued.
- `s` and `r` are never high in the same cycle.
- `s` and `r` are never high in two consecutive cycles.

## Timing
- Reference point: a raw input changes and is first captured by `sync1` at edge k.
  - `sync2` changes at edge k+1.
  - `lvl` changes at edge k+1+`DB_CYCLES`.
  - `s`/`r` go high after edge k+2+`DB_CYCLES`, for exactly one cycle.
- Total latency from capture to command: `DB_CYCLES`+2 cycles (6 at defaults).
- `conflict` and `drop` are aligned to the same edge as the command they relate to.
- Minimum spacing between two commands: `LOCKOUT`+1 cycles. An edge in the first IDLE cycle after LOCK is accepted.
- Counter widths are 8 bits. No wrap: every counter is cleared at its terminal value.

## Structure
- Package `sr_cmd_pkg` holds:
  - the FSM state enum `{IDLE, LOCK}`;
  - defaults `DB_CYCLES_DEF = 4` and `LOCKOUT_DEF = 8`;
  - the counter width constant `CNT_W = 8`.
- Sub-module `debounce_ch`:
  - contents: synchroniser, debounce counter, `lvl` and `lvl_q`, rise flag;
  - instantiated twice, once per channel;
  - parameterised by `DB_CYCLES`.
- Top level contains the arbiter FSM, lock counter and output registers only.

## Test plan
All scenarios use defaults `DB_CYCLES=4`, `LOCKOUT=8`.
1. `set_in` rises and stays high.
   - `set_lvl` rises 5 edges after capture.
   - `s` pulses once, 6 cycles after capture.
   - `r`, `conflict`, `drop` stay 0.
2. `clr_in` has a 3-cycle glitch, then a clean high.
   - Glitch: no `clr_lvl` change, no `r`.
   - Clean high: one `r` pulse, 6 cycles after capture.
3. `set_in` and `clr_in` rise on the same cycle.
   - One `s` pulse with `conflict`=1 in the same cycle.
   - `r` never asserts.
4. Set edge, then clear raised so its rise lands 3 cycles into LOCK.
   - `drop` pulses in that cycle.
   - No `r` follows.
   - A second clear edge landing after the 8-cycle LOCK yields `r`.
5. `rst_n` asserted mid-debounce (counter at 2) and mid-LOCK.
   - All outputs go to 0 immediately; FSM returns to IDLE.
   - With `set_in` held high through release, exactly one `s` appears 6 cycles after release.
